// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//
// Multi-port integer register file with a per-register pending-write
// scoreboard. Decode reads operands and marks long-latency destinations as
// busy. Writeback retires up to two results per cycle, and each enabled
// write clears the busy flag of its destination.
//
// Ports
//   cpu_clk    : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   stall      : freezes all register, busy and busy_cnt updates
//   rs         : NRD packed read addresses, port i = rs[i*AW +: AW]
//   rdata      : NRD packed read data, port i = rdata[i*XLEN +: XLEN]
//   rbusy      : per-port "source has a pending write"
//   wb0_*      : writeback lane 0 (older instruction)
//   wb1_*      : writeback lane 1 (younger instruction, wins on conflicts)
//   iss_valid  : issue of a long-latency producer; iss_rd is marked busy
//   busy_cnt   : registered popcount of the busy flags
//
// Handshake semantics: wb0_sig, wb1_sig and iss_valid are single-cycle
// qualifiers with no ready back-pressure. A request takes effect on the
// rising edge where it is high, stall is low and its register index is
// nonzero and below NREG. Otherwise it is dropped.
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int               XLEN    = 32,
  parameter int               NREG    = 32,
  parameter int               NRD     = 2,
  parameter int               BYPASS  = 1,
  parameter logic [XLEN-1:0]  RA_INIT = {XLEN{1'b1}},
  parameter logic [31:0]      SP_INIT = 32'h0000_3FFC,
  localparam int              AW      = $clog2(NREG)
) (
  input  logic                 cpu_clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NRD*AW-1:0]    rs,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 wb0_sig,
  input  logic [AW-1:0]        wb0_rd,
  input  logic [XLEN-1:0]      wb0_data,
  input  logic                 wb1_sig,
  input  logic [AW-1:0]        wb1_rd,
  input  logic [XLEN-1:0]      wb1_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [AW:0]          busy_cnt
);

  // SP_INIT is a 32-bit constant. It is zero-extended or truncated to XLEN.
  localparam logic [XLEN-1:0] SP_RST = XLEN'(SP_INIT);
  localparam logic [AW:0]     NREG_L = (AW+1)'(NREG);
  localparam logic            BYP    = (BYPASS != 0);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;

  // Register 0 and indices at or above NREG are not architectural targets.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_L);
  endfunction

  function automatic logic [XLEN-1:0] reg_rst(input int r);
    logic [XLEN-1:0] v;
    v = '0;
    if (r == 1) v = RA_INIT;
    if (r == 2) v = SP_RST;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Enables
  // -------------------------------------------------------------------------
  logic wb0_en;
  logic wb1_en;
  logic iss_en;

  assign wb0_en = wb0_sig   && !stall && addr_ok(wb0_rd);
  assign wb1_en = wb1_sig   && !stall && addr_ok(wb1_rd);
  assign iss_en = iss_valid && !stall && addr_ok(iss_rd);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    // Lane 1 is applied last so it overrides lane 0 on the same target.
    if (wb0_en) regs_d[wb0_rd] = wb0_data;
    if (wb1_en) regs_d[wb1_rd] = wb1_data;
  end

  always_comb begin
    busy_d = busy_q;
    if (wb0_en) busy_d[wb0_rd] = 1'b0;
    if (wb1_en) busy_d[wb1_rd] = 1'b0;
    // Set after clear: a newly issued producer supersedes a retiring one.
    if (iss_en) busy_d[iss_rd] = 1'b1;
  end

  // busy_cnt tracks the busy flags as they will be after this edge.
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= reg_rst(r);
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            ok;
    logic            hit0;
    logic            hit1;
    logic [XLEN-1:0] val;

    assign addr = rs[gi*AW +: AW];
    assign ok   = addr_ok(addr);
    assign hit0 = BYP && wb0_en && (wb0_rd == addr);
    assign hit1 = BYP && wb1_en && (wb1_rd == addr);

    always_comb begin
      val = '0;
      if (ok) begin
        if (hit1)      val = wb1_data;
        else if (hit0) val = wb0_data;
        else           val = regs_q[addr];
      end
    end

    assign rdata[gi*XLEN +: XLEN] = val;
    // A retiring producer unblocks its consumer in the same cycle when the
    // result is forwarded.
    assign rbusy[gi] = ok && busy_q[addr] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
//
// Directed bench for regfile_mp_sb. Two instances share all inputs: dut
// (BYPASS=1) and dut_nb (BYPASS=0). The driver sets the inputs one time unit
// after a rising edge and pushes the expected values for that cycle. The
// monitor pops and compares them on the following falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  localparam int S_RD0    = 0;
  localparam int S_RD1    = 1;
  localparam int S_RBUSY  = 2;
  localparam int S_CNT    = 3;
  localparam int S_NB_RD0 = 4;
  localparam int S_NB_RB  = 5;
  localparam int S_NB_CNT = 6;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 stall;
  logic [NRD*AW-1:0]    rs;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD*XLEN-1:0]  rdata_nb;
  logic [NRD-1:0]       rbusy;
  logic [NRD-1:0]       rbusy_nb;
  logic                 wb0_sig;
  logic [AW-1:0]        wb0_rd;
  logic [XLEN-1:0]      wb0_data;
  logic                 wb1_sig;
  logic [AW-1:0]        wb1_rd;
  logic [XLEN-1:0]      wb1_data;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic [AW:0]          busy_cnt;
  logic [AW:0]          busy_cnt_nb;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut (
    .cpu_clk  (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .rs       (rs),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wb0_sig  (wb0_sig),
    .wb0_rd   (wb0_rd),
    .wb0_data (wb0_data),
    .wb1_sig  (wb1_sig),
    .wb1_rd   (wb1_rd),
    .wb1_data (wb1_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .busy_cnt (busy_cnt)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_nb (
    .cpu_clk  (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .rs       (rs),
    .rdata    (rdata_nb),
    .rbusy    (rbusy_nb),
    .wb0_sig  (wb0_sig),
    .wb0_rd   (wb0_rd),
    .wb0_data (wb0_data),
    .wb1_sig  (wb1_sig),
    .wb1_rd   (wb1_rd),
    .wb1_data (wb1_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .busy_cnt (busy_cnt_nb)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] exp_q[$];
  int              sel_q[$];
  string           name_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [XLEN-1:0] mon_exp;
  logic [XLEN-1:0] mon_act;
  int              mon_sel;
  string           mon_name;

  task automatic expect_v(input int sel, input logic [XLEN-1:0] v, input string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_sel  = sel_q.pop_front();
        mon_name = name_q.pop_front();
        case (mon_sel)
          S_RD0:    mon_act = rdata[XLEN-1:0];
          S_RD1:    mon_act = rdata[2*XLEN-1:XLEN];
          S_RBUSY:  mon_act = {{(XLEN-NRD){1'b0}}, rbusy};
          S_CNT:    mon_act = {{(XLEN-AW-1){1'b0}}, busy_cnt};
          S_NB_RD0: mon_act = rdata_nb[XLEN-1:0];
          S_NB_RB:  mon_act = {{(XLEN-NRD){1'b0}}, rbusy_nb};
          S_NB_CNT: mon_act = {{(XLEN-AW-1){1'b0}}, busy_cnt_nb};
          default:  mon_act = 'x;
        endcase
        chk_cnt++;
        if (mon_act === mon_exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall     = 1'b0;
    wb0_sig   = 1'b0;
    wb0_rd    = '0;
    wb0_data  = '0;
    wb1_sig   = 1'b0;
    wb1_rd    = '0;
    wb1_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic set_rs(input int a, input int b);
    logic [AW-1:0] aa;
    logic [AW-1:0] bb;
    aa = AW'(a);
    bb = AW'(b);
    rs = {bb, aa};
  endtask

  task automatic wb0(input int r, input logic [XLEN-1:0] d);
    wb0_sig  = 1'b1;
    wb0_rd   = AW'(r);
    wb0_data = d;
  endtask

  task automatic wb1(input int r, input logic [XLEN-1:0] d);
    wb1_sig  = 1'b1;
    wb1_rd   = AW'(r);
    wb1_data = d;
  endtask

  task automatic iss(input int r);
    iss_valid = 1'b1;
    iss_rd    = AW'(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    idle();
    set_rs(0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    set_rs(1, 2);
    expect_v(S_RD0,   32'hFFFF_FFFF, "rst_reg1");
    expect_v(S_RD1,   32'h0000_3FFC, "rst_reg2");
    expect_v(S_RBUSY, 32'd0,         "rst_rbusy");
    expect_v(S_CNT,   32'd0,         "rst_busy_cnt");
    step();
    for (int r = 3; r < NREG; r += 2) begin
      set_rs(r, (r + 1) % NREG);
      expect_v(S_RD0, 32'd0, "rst_regs_lo");
      expect_v(S_RD1, 32'd0, "rst_regs_hi");
      step();
    end
    set_rs(0, 0);
    expect_v(S_RD0,   32'd0, "reg0_read");
    expect_v(S_RBUSY, 32'd0, "reg0_rbusy");
    step();

    wb0(5, 32'hA5A5_A5A5);
    set_rs(5, 5);
    expect_v(S_RD0,    32'hA5A5_A5A5, "bypass_reg5");
    expect_v(S_NB_RD0, 32'd0,         "nobypass_reg5_before");
    step();
    idle();
    expect_v(S_RD0,    32'hA5A5_A5A5, "stored_reg5");
    expect_v(S_NB_RD0, 32'hA5A5_A5A5, "nobypass_reg5_after");
    step();

    wb0(7, 32'h11);
    wb1(7, 32'h22);
    set_rs(7, 7);
    expect_v(S_RD0,    32'h22, "bypass_lane1_wins");
    expect_v(S_NB_RD0, 32'h0,  "nobypass_reg7_before");
    step();
    idle();
    expect_v(S_RD0,    32'h22, "stored_lane1_wins");
    expect_v(S_NB_RD0, 32'h22, "nobypass_reg7_after");
    step();

    wb0(0, 32'hDEAD_BEEF);
    set_rs(0, 5);
    expect_v(S_RD0, 32'd0,         "reg0_write_bypass");
    expect_v(S_RD1, 32'hA5A5_A5A5, "reg5_unchanged");
    step();
    idle();
    expect_v(S_RD0,    32'd0, "reg0_after_write");
    expect_v(S_NB_RD0, 32'd0, "reg0_after_write_nb");
    step();

    iss(9);
    set_rs(9, 9);
    expect_v(S_RBUSY, 32'd0, "iss9_same_cycle_rbusy");
    expect_v(S_CNT,   32'd0, "iss9_same_cycle_cnt");
    step();
    idle();
    expect_v(S_RBUSY, 32'd3, "iss9_rbusy");
    expect_v(S_CNT,   32'd1, "iss9_cnt");
    step();
    wb1(9, 32'h99);
    expect_v(S_RBUSY,  32'd0,  "retire9_rbusy_bypass");
    expect_v(S_NB_RB,  32'd3,  "retire9_rbusy_nobypass");
    expect_v(S_RD0,    32'h99, "retire9_rdata");
    expect_v(S_CNT,    32'd1,  "retire9_cnt_same_cycle");
    step();
    idle();
    expect_v(S_CNT,    32'd0,  "retire9_cnt_next");
    expect_v(S_RBUSY,  32'd0,  "retire9_rbusy_next");
    expect_v(S_NB_RD0, 32'h99, "retire9_stored_nb");
    step();

    iss(4);
    wb0(4, 32'h44);
    set_rs(4, 4);
    expect_v(S_RD0,   32'h44, "iss_wb4_bypass");
    expect_v(S_RBUSY, 32'd0,  "iss_wb4_rbusy_before");
    step();
    idle();
    expect_v(S_RD0,    32'h44, "iss_wb4_stored");
    expect_v(S_RBUSY,  32'd3,  "iss_wb4_busy_kept");
    expect_v(S_CNT,    32'd1,  "iss_wb4_cnt");
    expect_v(S_NB_CNT, 32'd1,  "iss_wb4_cnt_nb");
    step();

    stall = 1'b1;
    wb0(6, 32'h66);
    wb1(4, 32'h55);
    iss(8);
    set_rs(6, 4);
    expect_v(S_RD0,   32'd0,  "stall_no_bypass6");
    expect_v(S_RD1,   32'h44, "stall_no_bypass4");
    expect_v(S_RBUSY, 32'd2,  "stall_rbusy");
    expect_v(S_CNT,   32'd1,  "stall_cnt");
    step();
    idle();
    set_rs(6, 8);
    expect_v(S_RD0,   32'd0, "stall_reg6_kept");
    expect_v(S_RBUSY, 32'd0, "stall_no_iss8");
    expect_v(S_CNT,   32'd1, "stall_cnt_after");
    step();
    set_rs(4, 0);
    expect_v(S_RD0,   32'h44, "stall_reg4_kept");
    expect_v(S_RBUSY, 32'd1,  "stall_busy4_kept");
    step();

    iss(4);
    step();
    iss(12);
    expect_v(S_CNT, 32'd1, "reissue4_cnt");
    step();
    idle();
    set_rs(12, 4);
    expect_v(S_CNT,   32'd2, "iss12_cnt");
    expect_v(S_RBUSY, 32'd3, "iss12_rbusy");
    step();

    set_rs(1, 4);
    rst_n = 1'b0;
    expect_v(S_RD0,    32'hFFFF_FFFF, "async_rst_reg1");
    expect_v(S_RD1,    32'd0,         "async_rst_reg4");
    expect_v(S_RBUSY,  32'd0,         "async_rst_rbusy");
    expect_v(S_CNT,    32'd0,         "async_rst_cnt");
    expect_v(S_NB_RD0, 32'hFFFF_FFFF, "async_rst_reg1_nb");
    step();
    set_rs(5, 7);
    expect_v(S_RD0, 32'd0, "async_rst_reg5");
    expect_v(S_RD1, 32'd0, "async_rst_reg7");
    step();
    rst_n = 1'b1;
    set_rs(2, 12);
    expect_v(S_RD1,   32'd0,         "post_rst_reg12");
    expect_v(S_RD0,   32'h0000_3FFC, "post_rst_reg2");
    expect_v(S_RBUSY, 32'd0,         "post_rst_rbusy");
    step();
    step();

    #1;
    chk_cnt++;
    if (rdata[XLEN-1:0] === 32'h0000_3FFC) pass_cnt++;
    else $display("FAIL final_reg2: got %h expected %h", rdata[XLEN-1:0], 32'h0000_3FFC);
    chk_cnt++;
    if (rdata_nb[XLEN-1:0] === 32'h0000_3FFC) pass_cnt++;
    else $display("FAIL final_reg2_nb: got %h expected %h", rdata_nb[XLEN-1:0], 32'h0000_3FFC);
    chk_cnt++;
    if (busy_cnt === '0) pass_cnt++;
    else $display("FAIL final_busy_cnt: got %h expected %h", busy_cnt, 0);
    chk_cnt++;
    if (rbusy === '0) pass_cnt++;
    else $display("FAIL final_rbusy: got %h expected %h", rbusy, 0);
    chk_cnt++;
    if (rbusy_nb === '0) pass_cnt++;
    else $display("FAIL final_rbusy_nb: got %h expected %h", rbusy_nb, 0);

    while (exp_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL unconsumed %s: got none expected %h", name_q.pop_front(), exp_q.pop_front());
      void'(sel_q.pop_front());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
